// File: rtl/dma_client_axis_source.sv
// Reads descriptors, fetches beats from a segmented RAM and streams them out over AXI-Stream.
// Optional macro DMA_CLIENT_AXIS_SOURCE_ENABLE_GATE_EN gates descriptor acceptance with enable.
module dma_client_axis_source #(
    parameter int SEG_COUNT        = 2,
    parameter int SEG_DATA_WIDTH   = 256,
    parameter int SEG_BE_WIDTH     = SEG_DATA_WIDTH/8,
    parameter int SEG_ADDR_WIDTH   = 8,
    parameter int RAM_ADDR_WIDTH   = SEG_ADDR_WIDTH+$clog2(SEG_COUNT*SEG_BE_WIDTH),
    parameter int AXIS_DATA_WIDTH  = SEG_COUNT*SEG_DATA_WIDTH,
    parameter int AXIS_KEEP_ENABLE = 1,
    parameter int AXIS_LAST_ENABLE = 1,
    parameter int AXIS_ID_ENABLE   = 0,
    parameter int AXIS_ID_WIDTH    = 8,
    parameter int AXIS_DEST_ENABLE = 0,
    parameter int AXIS_DEST_WIDTH  = 8,
    parameter int AXIS_USER_ENABLE = 0,
    parameter int AXIS_USER_WIDTH  = 1,
    parameter int LEN_WIDTH        = 16,
    parameter int TAG_WIDTH        = 8
) (
    input  logic                                clk,
    input  logic                                rst,

    input  logic [RAM_ADDR_WIDTH-1:0]           s_axis_read_desc_ram_addr,
    input  logic [LEN_WIDTH-1:0]                s_axis_read_desc_len,
    input  logic [TAG_WIDTH-1:0]                s_axis_read_desc_tag,
    input  logic [AXIS_ID_WIDTH-1:0]            s_axis_read_desc_id,
    input  logic [AXIS_DEST_WIDTH-1:0]          s_axis_read_desc_dest,
    input  logic [AXIS_USER_WIDTH-1:0]          s_axis_read_desc_user,
    input  logic                                s_axis_read_desc_valid,
    output logic                                s_axis_read_desc_ready,

    output logic [TAG_WIDTH-1:0]                m_axis_read_desc_status_tag,
    output logic [3:0]                          m_axis_read_desc_status_error,
    output logic                                m_axis_read_desc_status_valid,

    output logic [AXIS_DATA_WIDTH-1:0]          m_axis_read_data_tdata,
    output logic [AXIS_DATA_WIDTH/8-1:0]        m_axis_read_data_tkeep,
    output logic                                m_axis_read_data_tvalid,
    input  logic                                m_axis_read_data_tready,
    output logic                                m_axis_read_data_tlast,
    output logic [AXIS_ID_WIDTH-1:0]            m_axis_read_data_tid,
    output logic [AXIS_DEST_WIDTH-1:0]          m_axis_read_data_tdest,
    output logic [AXIS_USER_WIDTH-1:0]          m_axis_read_data_tuser,

    output logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] ram_rd_cmd_addr,
    output logic [SEG_COUNT-1:0]                ram_rd_cmd_valid,
    input  logic [SEG_COUNT-1:0]                ram_rd_cmd_ready,
    input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] ram_rd_resp_data,
    input  logic [SEG_COUNT-1:0]                ram_rd_resp_valid,
    output logic [SEG_COUNT-1:0]                ram_rd_resp_ready,

    input  logic                                enable
);

    localparam int unsigned KEEP_W = AXIS_DATA_WIDTH/8;
    localparam int unsigned OFFS   = $clog2(KEEP_W);
    localparam logic [LEN_WIDTH:0] BEAT_ROUND = (LEN_WIDTH+1)'(KEEP_W-1);
    localparam logic [LEN_WIDTH:0] ONE_BEAT   = (LEN_WIDTH+1)'(1);

    typedef enum logic [0:0] {IDLE, READ} state_t;

    state_t                     state_q, state_d;
    logic [SEG_ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [LEN_WIDTH:0]         cmd_rem_q, cmd_rem_d;
    logic [LEN_WIDTH:0]         out_rem_q, out_rem_d;
    logic [2:0]                 outst_q, outst_d;
    logic [SEG_COUNT-1:0]       seg_done_q, seg_done_d;
    logic [KEEP_W-1:0]          last_keep_q, last_keep_d;
    logic [TAG_WIDTH-1:0]       tag_q, tag_d;
    logic [TAG_WIDTH-1:0]       stat_tag_q, stat_tag_d;
    logic                       stat_valid_q, stat_valid_d;
    logic [AXIS_ID_WIDTH-1:0]   id_q, id_d;
    logic [AXIS_DEST_WIDTH-1:0] dest_q, dest_d;
    logic [AXIS_USER_WIDTH-1:0] user_q, user_d;
    logic [2:0]                 wr_ptr_q, wr_ptr_d;
    logic [2:0]                 rd_ptr_q, rd_ptr_d;
    logic [AXIS_DATA_WIDTH-1:0] mem_q [4];

    logic [LEN_WIDTH:0]         desc_beats;
    logic [OFFS-1:0]            len_rem;
    logic                       desc_accept;
    logic [2:0]                 fifo_count;
    logic                       fifo_full, fifo_empty, fifo_wr, fifo_rd;
    logic                       last_beat;
    logic                       cmd_active, cmd_done;
    logic [SEG_COUNT-1:0]       seg_hs;

    logic [OFFS+AXIS_ID_WIDTH+AXIS_DEST_WIDTH+AXIS_USER_WIDTH:0] unused_bits;
    assign unused_bits = {enable, s_axis_read_desc_ram_addr[OFFS-1:0], id_q, dest_q, user_q};

`ifdef DMA_CLIENT_AXIS_SOURCE_ENABLE_GATE_EN
    assign s_axis_read_desc_ready = (state_q == IDLE) && !rst && enable;
`else
    assign s_axis_read_desc_ready = (state_q == IDLE) && !rst;
`endif

    assign desc_accept = s_axis_read_desc_valid && s_axis_read_desc_ready;
    assign desc_beats  = ({1'b0, s_axis_read_desc_len} + BEAT_ROUND) >> OFFS;
    assign len_rem     = s_axis_read_desc_len[OFFS-1:0];

    assign fifo_count  = wr_ptr_q - rd_ptr_q;
    assign fifo_full   = fifo_count[2];
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    // Responses are only taken once every segment has its half of the beat.
    assign fifo_wr     = (state_q == READ) && !fifo_full && (&ram_rd_resp_valid);
    assign fifo_rd     = !fifo_empty && m_axis_read_data_tready;
    assign last_beat   = (out_rem_q == ONE_BEAT);

    assign ram_rd_resp_ready = ((state_q == READ) && !fifo_full) ? '1 : '0;

    assign cmd_active       = (state_q == READ) && (cmd_rem_q != '0) && !outst_q[2];
    assign ram_rd_cmd_valid = {SEG_COUNT{cmd_active}} & ~seg_done_q;
    assign ram_rd_cmd_addr  = {SEG_COUNT{addr_q}};
    assign seg_hs           = ram_rd_cmd_valid & ram_rd_cmd_ready;
    assign cmd_done         = cmd_active && (&(seg_done_q | seg_hs));

    assign m_axis_read_data_tvalid = !fifo_empty;
    assign m_axis_read_data_tdata  = mem_q[rd_ptr_q[1:0]];
    assign m_axis_read_data_tkeep  = (AXIS_KEEP_ENABLE != 0 && last_beat) ? last_keep_q : '1;
    assign m_axis_read_data_tlast  = (AXIS_LAST_ENABLE != 0) ? (!fifo_empty && last_beat) : 1'b1;
    assign m_axis_read_data_tid    = (AXIS_ID_ENABLE != 0)   ? id_q   : '0;
    assign m_axis_read_data_tdest  = (AXIS_DEST_ENABLE != 0) ? dest_q : '0;
    assign m_axis_read_data_tuser  = (AXIS_USER_ENABLE != 0) ? user_q : '0;

    assign m_axis_read_desc_status_tag   = stat_tag_q;
    assign m_axis_read_desc_status_error = 4'd0;
    assign m_axis_read_desc_status_valid = stat_valid_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        cmd_rem_d    = cmd_rem_q;
        out_rem_d    = out_rem_q;
        outst_d      = outst_q;
        seg_done_d   = seg_done_q;
        last_keep_d  = last_keep_q;
        tag_d        = tag_q;
        id_d         = id_q;
        dest_d       = dest_q;
        user_d       = user_q;
        stat_valid_d = 1'b0;
        stat_tag_d   = stat_tag_q;
        wr_ptr_d     = wr_ptr_q + {2'b00, fifo_wr};
        rd_ptr_d     = rd_ptr_q + {2'b00, fifo_rd};

        case (state_q)
            IDLE: begin
                if (desc_accept) begin
                    addr_d      = s_axis_read_desc_ram_addr[OFFS +: SEG_ADDR_WIDTH];
                    tag_d       = s_axis_read_desc_tag;
                    id_d        = s_axis_read_desc_id;
                    dest_d      = s_axis_read_desc_dest;
                    user_d      = s_axis_read_desc_user;
                    last_keep_d = (len_rem == '0) ? '1 : ~({KEEP_W{1'b1}} << len_rem);
                    cmd_rem_d   = desc_beats;
                    out_rem_d   = desc_beats;
                    outst_d     = '0;
                    seg_done_d  = '0;
                    if (desc_beats == '0) begin
                        stat_valid_d = 1'b1;
                        stat_tag_d   = s_axis_read_desc_tag;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                // Remember which segments already took the command so each is issued once per beat.
                seg_done_d = cmd_done ? '0 : (seg_done_q | seg_hs);
                outst_d    = outst_q + {2'b00, cmd_done} - {2'b00, fifo_rd};
                if (cmd_done) begin
                    addr_d    = addr_q + 1'b1;
                    cmd_rem_d = cmd_rem_q - ONE_BEAT;
                end
                if (fifo_rd) begin
                    out_rem_d = out_rem_q - ONE_BEAT;
                    if (last_beat) begin
                        state_d      = IDLE;
                        stat_valid_d = 1'b1;
                        stat_tag_d   = tag_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            cmd_rem_q    <= '0;
            out_rem_q    <= '0;
            outst_q      <= '0;
            seg_done_q   <= '0;
            last_keep_q  <= '1;
            tag_q        <= '0;
            id_q         <= '0;
            dest_q       <= '0;
            user_q       <= '0;
            stat_valid_q <= 1'b0;
            stat_tag_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            cmd_rem_q    <= cmd_rem_d;
            out_rem_q    <= out_rem_d;
            outst_q      <= outst_d;
            seg_done_q   <= seg_done_d;
            last_keep_q  <= last_keep_d;
            tag_q        <= tag_d;
            id_q         <= id_d;
            dest_q       <= dest_d;
            user_q       <= user_d;
            stat_valid_q <= stat_valid_d;
            stat_tag_q   <= stat_tag_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_q[wr_ptr_q[1:0]] <= ram_rd_resp_data;
        end
    end

endmodule

// File: tb/tb_dma_client_axis_source.sv
// Scoreboard bench for dma_client_axis_source with a two-segment RAM model and AXIS monitor.
module tb_dma_client_axis_source;

    localparam int SEG_COUNT      = 2;
    localparam int SEG_DATA_WIDTH = 256;
    localparam int SEG_ADDR_WIDTH = 8;
    localparam int RAM_ADDR_WIDTH = 14;
    localparam int AXIS_DATA_WIDTH = 512;
    localparam int LEN_WIDTH      = 16;
    localparam int TAG_WIDTH      = 8;

    logic         clk;
    logic         rst;
    logic [13:0]  desc_addr;
    logic [15:0]  desc_len;
    logic [7:0]   desc_tag;
    logic [7:0]   desc_id;
    logic [7:0]   desc_dest;
    logic [0:0]   desc_user;
    logic         desc_valid;
    logic         desc_ready;
    logic [7:0]   status_tag;
    logic [3:0]   status_error;
    logic         status_valid;
    logic [511:0] tdata;
    logic [63:0]  tkeep;
    logic         tvalid;
    logic         tready;
    logic         tlast;
    logic [7:0]   tid;
    logic [7:0]   tdest;
    logic [0:0]   tuser;
    logic [15:0]  cmd_addr;
    logic [1:0]   cmd_valid;
    logic [1:0]   cmd_ready;
    logic [511:0] resp_data;
    logic [1:0]   resp_valid;
    logic [1:0]   resp_ready;
    logic         enable;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  stat_q[$];
    int          checks;
    int          errors;
    int          seg0_cmds;
    int          seg1_cmds;
    int          bp_mode;

    dma_client_axis_source #(
        .SEG_COUNT(SEG_COUNT),
        .SEG_DATA_WIDTH(SEG_DATA_WIDTH),
        .SEG_ADDR_WIDTH(SEG_ADDR_WIDTH),
        .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH),
        .AXIS_DATA_WIDTH(AXIS_DATA_WIDTH),
        .LEN_WIDTH(LEN_WIDTH),
        .TAG_WIDTH(TAG_WIDTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis_read_desc_ram_addr(desc_addr),
        .s_axis_read_desc_len(desc_len),
        .s_axis_read_desc_tag(desc_tag),
        .s_axis_read_desc_id(desc_id),
        .s_axis_read_desc_dest(desc_dest),
        .s_axis_read_desc_user(desc_user),
        .s_axis_read_desc_valid(desc_valid),
        .s_axis_read_desc_ready(desc_ready),
        .m_axis_read_desc_status_tag(status_tag),
        .m_axis_read_desc_status_error(status_error),
        .m_axis_read_desc_status_valid(status_valid),
        .m_axis_read_data_tdata(tdata),
        .m_axis_read_data_tkeep(tkeep),
        .m_axis_read_data_tvalid(tvalid),
        .m_axis_read_data_tready(tready),
        .m_axis_read_data_tlast(tlast),
        .m_axis_read_data_tid(tid),
        .m_axis_read_data_tdest(tdest),
        .m_axis_read_data_tuser(tuser),
        .ram_rd_cmd_addr(cmd_addr),
        .ram_rd_cmd_valid(cmd_valid),
        .ram_rd_cmd_ready(cmd_ready),
        .ram_rd_resp_data(resp_data),
        .ram_rd_resp_valid(resp_valid),
        .ram_rd_resp_ready(resp_ready),
        .enable(enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] seg_word(input logic [7:0] s, input logic [7:0] a);
        logic [31:0] w;
        w = {s, 8'hA5, a, a ^ 8'h3C};
        return {8{w}};
    endfunction

    function automatic logic [511:0] beat_word(input logic [7:0] a);
        return {seg_word(8'd1, a), seg_word(8'd0, a)};
    endfunction

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    // RAM model: inputs change on the falling edge, handshakes sampled just before the rising edge.
    initial begin : ram_model
        logic [7:0]   q0[$];
        logic [7:0]   q1[$];
        logic         rv, hs0, hs1, hsr;
        logic [7:0]   a0s, a1s, a0, a1;
        logic [511:0] rdata;
        int unsigned  cyc;
        rv = 1'b0; hs0 = 1'b0; hs1 = 1'b0; hsr = 1'b0;
        a0s = '0; a1s = '0; rdata = '0; cyc = 0;
        seg0_cmds = 0; seg1_cmds = 0;
        cmd_ready = '0; resp_valid = '0; resp_data = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                q0.delete(); q1.delete();
                rv = 1'b0; hs0 = 1'b0; hs1 = 1'b0; hsr = 1'b0;
            end else begin
                if (hs0) begin q0.push_back(a0s); seg0_cmds++; end
                if (hs1) begin q1.push_back(a1s); seg1_cmds++; end
                if (hsr) rv = 1'b0;
                if (!rv && q0.size() > 0 && q1.size() > 0) begin
                    a0 = q0.pop_front();
                    a1 = q1.pop_front();
                    rdata = {seg_word(8'd1, a1), seg_word(8'd0, a0)};
                    rv = 1'b1;
                end
            end
            cmd_ready  = {(cyc % 3) != 0, 1'b1};
            resp_valid = {rv, rv};
            resp_data  = rdata;
            #4;
            hs0 = cmd_valid[0] && cmd_ready[0];
            hs1 = cmd_valid[1] && cmd_ready[1];
            a0s = cmd_addr[7:0];
            a1s = cmd_addr[15:8];
            hsr = rv && (&resp_ready) && !rst;
        end
    end

    initial begin : tready_drv
        int unsigned k;
        k = 0;
        tready = 1'b1;
        forever begin
            @(negedge clk);
            k++;
            case (bp_mode)
                0:       tready = 1'b1;
                1:       tready = (k % 4) != 3;
                default: tready = 1'b0;
            endcase
        end
    end

    initial begin : monitor
        logic  pend_status;
        beat_t b;
        pend_status = 1'b0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                pend_status = 1'b0;
            end else begin
                if (pend_status) check("status_after_last", 512'(status_valid), 512'(1));
                pend_status = 1'b0;
                if (status_valid) begin
                    if (stat_q.size() == 0) flag_fail("status_unexpected");
                    else begin
                        check("status_tag", 512'(status_tag), 512'(stat_q.pop_front()));
                        check("status_error", 512'(status_error), 512'(0));
                    end
                end
                if (tvalid && tready) begin
                    if (exp_q.size() == 0) flag_fail("beat_unexpected");
                    else begin
                        b = exp_q.pop_front();
                        check("tdata", tdata, b.data);
                        check("tkeep", 512'(tkeep), 512'(b.keep));
                        check("tlast", 512'(tlast), 512'(b.last));
                        if (tlast) pend_status = 1'b1;
                    end
                end
            end
        end
    end

    task automatic push_expected(input logic [13:0] addr, input logic [7:0] tag,
                                 input int nbeats, input logic [63:0] lkeep);
        beat_t      b;
        logic [7:0] base;
        base = addr[13:6];
        for (int i = 0; i < nbeats; i++) begin
            b.data = beat_word(base + 8'(i));
            b.keep = (i == nbeats - 1) ? lkeep : '1;
            b.last = (i == nbeats - 1);
            exp_q.push_back(b);
        end
        stat_q.push_back(tag);
    endtask

    task automatic send(input logic [13:0] addr, input logic [15:0] len, input logic [7:0] tag,
                        input int nbeats, input logic [63:0] lkeep);
        bit ok;
        @(negedge clk);
        desc_addr = addr; desc_len = len; desc_tag = tag; desc_valid = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            #4;
            if (desc_ready) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) flag_fail("desc_accept_timeout");
        else push_expected(addr, tag, nbeats, lkeep);
        @(negedge clk);
        desc_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit done;
        done = 1'b0;
        for (int n = 0; n < 3000 && !done; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && stat_q.size() == 0) done = 1'b1;
        end
        if (!done) flag_fail(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_desc_ready"},   512'(desc_ready),   512'(0));
        check({tag, "_status_valid"}, 512'(status_valid), 512'(0));
        check({tag, "_tvalid"},       512'(tvalid),       512'(0));
        check({tag, "_tlast"},        512'(tlast),        512'(0));
        check({tag, "_cmd_valid"},    512'(cmd_valid),    512'(0));
        check({tag, "_resp_ready"},   512'(resp_ready),   512'(0));
    endtask

    initial begin : stimulus
        int c0, c1;
        checks = 0; errors = 0; bp_mode = 0;
        rst = 1'b1; enable = 1'b1;
        desc_addr = '0; desc_len = '0; desc_tag = '0; desc_id = '0; desc_dest = '0; desc_user = '0;
        desc_valid = 1'b0;
        #2;
        check_reset_outputs("rst_init");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Directed vectors: {ram_addr, len, tag, beats, last-beat tkeep}
        send(14'h0000, 16'd128, 8'd1, 2, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done("done_len128");
        send(14'h0080, 16'd70, 8'd2, 2, 64'h0000_0000_0000_003F);
        wait_done("done_len70");
        bp_mode = 1;
        send(14'h3FC5, 16'd130, 8'd3, 3, 64'h0000_0000_0000_0003);
        wait_done("done_wrap");
        bp_mode = 0;
        send(14'h0100, 16'd1, 8'd4, 1, 64'h0000_0000_0000_0001);
        wait_done("done_len1");

        // Zero-length descriptor
        @(negedge clk);
        desc_addr = 14'h0040; desc_len = 16'd0; desc_tag = 8'd5; desc_valid = 1'b1;
        #4;
        check("len0_ready", 512'(desc_ready), 512'(1));
        stat_q.push_back(8'd5);
        @(negedge clk);
        desc_valid = 1'b0;
        #4;
        check("len0_status_valid", 512'(status_valid), 512'(1));
        check("len0_status_tag", 512'(status_tag), 512'(5));
        check("len0_tvalid", 512'(tvalid), 512'(0));
        check("len0_cmd_valid", 512'(cmd_valid), 512'(0));
        wait_done("done_len0");

        // Backpressure: 16-beat read with tready held low
        bp_mode = 2;
        @(negedge clk);
        c0 = seg0_cmds; c1 = seg1_cmds;
        send(14'h0200, 16'd1024, 8'd6, 16, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (10) @(negedge clk);
        #4;
        check("bp_seg0_cmds", 512'(seg0_cmds - c0), 512'(4));
        check("bp_seg1_cmds", 512'(seg1_cmds - c1), 512'(4));
        check("bp_cmd_valid", 512'(cmd_valid), 512'(0));
        check("bp_tvalid", 512'(tvalid), 512'(1));
        check("bp_resp_ready", 512'(resp_ready), 512'(0));
        @(negedge clk);
        bp_mode = 1;
        wait_done("done_bp");
        bp_mode = 0;

        // Reset mid-transfer, then a normal descriptor
        send(14'h0400, 16'd640, 8'd7, 10, 64'hFFFF_FFFF_FFFF_FFFF);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        exp_q.delete();
        stat_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        send(14'h0800, 16'd64, 8'd8, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done("done_after_rst");

`ifdef DMA_CLIENT_AXIS_SOURCE_ENABLE_GATE_EN
        enable = 1'b0;
        @(negedge clk);
        desc_addr = 14'h0C00; desc_len = 16'd64; desc_tag = 8'd9; desc_valid = 1'b1;
        repeat (5) @(negedge clk);
        #4;
        check("gate_ready_low", 512'(desc_ready), 512'(0));
        @(negedge clk);
        enable = 1'b1;
        #4;
        check("gate_ready_high", 512'(desc_ready), 512'(1));
        push_expected(14'h0C00, 8'd9, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        desc_valid = 1'b0;
        wait_done("done_gate");
`else
        enable = 1'b0;
        send(14'h0C00, 16'd64, 8'd9, 1, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_done("done_enable_ignored");
        enable = 1'b1;
`endif

        check("exp_beats_left", 512'(exp_q.size()), 512'(0));
        check("exp_status_left", 512'(stat_q.size()), 512'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
